// File: rtl/hazard_detection_unit.sv
// Hazard detection unit: load-use interlock, taken-branch flush, multi-cycle
// mul/div occupancy of EX and data-memory wait freeze, plus a saturating
// stall-cycle counter.
module hazard_detection_unit #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_IF_ID,
  input  logic [4:0]       rs2_IF_ID,
  input  logic             use_rs1_IF_ID,
  input  logic             use_rs2_IF_ID,
  input  logic [4:0]       rd_ID_EX,
  input  logic             mem_read_ID_EX,
  input  logic             branch_taken_EX,
  input  logic             muldiv_EX,
  input  logic             mem_req_EX_MEM,
  input  logic             dmem_ready,
  input  logic             stall_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             muldiv_busy,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_cycles
);

  // Down-counter only needs to hold MULDIV_LAT-2; keep at least one bit.
  localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CW-1:0]    CNT_LOAD  = CW'(MULDIV_LAT - 2);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  typedef enum logic {RUN, MULDIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic freeze;
  logic load_use;

  assign freeze   = mem_req_EX_MEM && !dmem_ready;
  assign load_use = mem_read_ID_EX && (rd_ID_EX != 5'd0) &&
                    ((use_rs1_IF_ID && (rs1_IF_ID == rd_ID_EX)) ||
                     (use_rs2_IF_ID && (rs2_IF_ID == rd_ID_EX)));

  // Prioritised pipeline control and next-state computation.
  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no
    // path through the priority chain can leave a latch behind.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    muldiv_done  = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;

    if (rst) begin
      // Hold every stage while reset is applied; any mul/div is abandoned.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      state_d      = RUN;
      cnt_d        = '0;
    end else if (freeze) begin
      // Whole pipeline waits on data memory; mul/div keeps counting down.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
      if (state_q == MULDIV && cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end else if (state_q == MULDIV) begin
      if (cnt_q != '0) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
        cnt_d        = cnt_q - CW'(1);
      end else begin
        muldiv_done = 1'b1;
        state_d     = RUN;
      end
    end else if (branch_taken_EX) begin
      // Squash the two wrong-path instructions; PC loads the target.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (muldiv_EX) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_flush = 1'b1;
      state_d      = MULDIV;
      cnt_d        = CNT_LOAD;
    end else if (load_use) begin
      // One bubble; next cycle the load is in MEM and forwarding covers it.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    stall_d = stall_q;
    if (stall_clear)                           stall_d = '0;
    else if (!pc_write && stall_q != STALL_MAX) stall_d = stall_q + CNT_W'(1);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled at the same edge.
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign muldiv_busy  = (state_q == MULDIV);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed, table-driven bench for hazard_detection_unit (MULDIV_LAT=4,
// CNT_W=4 so saturation is reachable quickly).
module tb_hazard_detection_unit;

  localparam int LAT = 4;
  localparam int CW  = 4;

  // Control vector order: {pc, if_id, id_ex, ex_mem, if_id_f, id_ex_f, ex_mem_f, mem_wb_f}
  localparam logic [7:0] C_DEF = 8'b1111_0000;
  localparam logic [7:0] C_LU  = 8'b0011_0100;
  localparam logic [7:0] C_BR  = 8'b1111_1100;
  localparam logic [7:0] C_MD  = 8'b0001_0010;
  localparam logic [7:0] C_FRZ = 8'b0000_0001;
  localparam logic [7:0] C_RST = 8'b0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_IF_ID, rs2_IF_ID, rd_ID_EX;
  logic          use_rs1_IF_ID, use_rs2_IF_ID, mem_read_ID_EX;
  logic          branch_taken_EX, muldiv_EX, mem_req_EX_MEM, dmem_ready, stall_clear;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic          muldiv_busy, muldiv_done;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  hazard_detection_unit #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .use_rs1_IF_ID(use_rs1_IF_ID), .use_rs2_IF_ID(use_rs2_IF_ID),
    .rd_ID_EX(rd_ID_EX), .mem_read_ID_EX(mem_read_ID_EX),
    .branch_taken_EX(branch_taken_EX), .muldiv_EX(muldiv_EX),
    .mem_req_EX_MEM(mem_req_EX_MEM), .dmem_ready(dmem_ready),
    .stall_clear(stall_clear),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mr, br, md, mreq, rdy;
    logic [7:0] ctl;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    rs1_IF_ID = v.rs1; rs2_IF_ID = v.rs2; rd_ID_EX = v.rd;
    use_rs1_IF_ID = v.use1; use_rs2_IF_ID = v.use2; mem_read_ID_EX = v.mr;
    branch_taken_EX = v.br; muldiv_EX = v.md;
    mem_req_EX_MEM = v.mreq; dmem_ready = v.rdy;
  endtask

  task automatic clear_in();
    vec_t z = '{default: '0};
    z.rdy = 1'b1;
    set_in(z);
  endtask

  // One cycle: check combinational outputs at negedge, advance the stall
  // model at posedge, then check the counter. exp_busy < 0 means don't care.
  task automatic cyc(input string name, input logic [7:0] ctl, input int exp_busy,
                     input logic exp_done);
    @(negedge clk);
    check({name, ".ctl"}, {24'd0, pc_write, if_id_write, id_ex_write, ex_mem_write,
                           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {24'd0, ctl});
    if (exp_busy >= 0) check({name, ".busy"}, {31'd0, muldiv_busy}, exp_busy);
    check({name, ".done"}, {31'd0, muldiv_done}, {31'd0, exp_done});
    @(posedge clk);
    if (rst || stall_clear)                       exp_stall = 0;
    else if (!ctl[7] && exp_stall < (1 << CW) - 1) exp_stall++;
    #1;
    check({name, ".stall"}, {28'd0, stall_cycles}, exp_stall);
  endtask

  initial begin
    //           rs1   rs2   rd    u1 u2 mr br md mq rdy ctl
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, C_DEF};
    vecs[1]  = '{5'd1, 5'd5, 5'd5, 1, 1, 1, 0, 0, 0, 1, C_LU};
    vecs[2]  = '{5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, 1, C_DEF};
    vecs[3]  = '{5'd1, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0, 1, C_DEF};
    vecs[4]  = '{5'd1, 5'd5, 5'd5, 0, 0, 1, 0, 0, 0, 1, C_DEF};
    vecs[5]  = '{5'd7, 5'd3, 5'd7, 1, 1, 1, 0, 0, 0, 1, C_LU};
    vecs[6]  = '{5'd7, 5'd3, 5'd7, 0, 1, 1, 0, 0, 0, 1, C_DEF};
    vecs[7]  = '{5'd1, 5'd5, 5'd5, 0, 1, 1, 1, 0, 0, 1, C_BR};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 1, C_BR};
    vecs[9]  = '{5'd1, 5'd5, 5'd5, 0, 1, 1, 1, 0, 1, 0, C_FRZ};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 1, C_DEF};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 0, C_FRZ};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, C_DEF};

    rst = 1'b1; stall_clear = 1'b0;
    clear_in();
    cyc("reset0", C_RST, -1, 1'b0);
    cyc("reset1", C_RST, 0, 1'b0);
    rst = 1'b0;

    // Single-cycle vectors in RUN; muldiv_busy must stay low throughout.
    foreach (vecs[i]) begin
      set_in(vecs[i]);
      cyc($sformatf("vec%0d", i), vecs[i].ctl, 0, 1'b0);
    end

    // Mul/div occupancy: three stalls, release on the fourth cycle.
    clear_in(); stall_clear = 1'b1;
    cyc("clr_a", C_DEF, 0, 1'b0);
    stall_clear = 1'b0;
    muldiv_EX = 1'b1;
    cyc("md0", C_MD, 0, 1'b0);
    cyc("md1", C_MD, 1, 1'b0);
    cyc("md2", C_MD, 1, 1'b0);
    cyc("md3", C_DEF, 1, 1'b1);
    muldiv_EX = 1'b0;
    cyc("md4", C_DEF, 0, 1'b0);
    check("md_stalls", {28'd0, stall_cycles}, 3);

    // Memory wait: three frozen cycles then defaults.
    mem_req_EX_MEM = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc($sformatf("frz%0d", k), C_FRZ, 0, 1'b0);
    dmem_ready = 1'b1;
    cyc("frz_rel", C_DEF, 0, 1'b0);
    mem_req_EX_MEM = 1'b0;

    // Freeze overlapping a mul/div: release slips past the freeze.
    muldiv_EX = 1'b1;
    cyc("ov0", C_MD, 0, 1'b0);
    mem_req_EX_MEM = 1'b1; dmem_ready = 1'b0;
    cyc("ov1", C_FRZ, 1, 1'b0);
    cyc("ov2", C_FRZ, 1, 1'b0);
    cyc("ov3", C_FRZ, 1, 1'b0);
    dmem_ready = 1'b1;
    cyc("ov4", C_DEF, 1, 1'b1);
    muldiv_EX = 1'b0; mem_req_EX_MEM = 1'b0;
    cyc("ov5", C_DEF, 0, 1'b0);

    // Reset while cnt=1 abandons the op.
    muldiv_EX = 1'b1;
    cyc("rm0", C_MD, 0, 1'b0);
    cyc("rm1", C_MD, 1, 1'b0);
    rst = 1'b1;
    cyc("rm_rst", C_RST, -1, 1'b0);
    rst = 1'b0; muldiv_EX = 1'b0;
    cyc("rm_after", C_DEF, 0, 1'b0);
    check("rm_stall", {28'd0, stall_cycles}, 0);

    // Saturation: 20 load-use stalls on a 4-bit counter.
    vecs[1].rdy = 1'b1;
    set_in(vecs[1]);
    for (int k = 0; k < 20; k++) cyc($sformatf("sat%0d", k), C_LU, 0, 1'b0);
    check("sat_value", {28'd0, stall_cycles}, 15);
    stall_clear = 1'b1;
    cyc("clr_stall", C_LU, 0, 1'b0);
    check("clr_value", {28'd0, stall_cycles}, 0);
    stall_clear = 1'b0;
    clear_in();
    cyc("final", C_DEF, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
